// File: rtl/fp16_to_fixed_serial_if.sv
// fp16_to_fixed_serial_if: operand/result handshake bundle for the fp16 to fixed-point converter
//   in_data/in_valid/in_ready    : fp16 operand stream into the converter
//   out_data/out_ovf/out_valid/out_ready : signed fixed-point result stream out of the converter
//   master = operand source and result sink, slave = converter
interface fp16_to_fixed_serial_if #(
  parameter int OUT_W = 16
);
  logic [15:0]      in_data;
  logic             in_valid;
  logic             in_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_ovf;
  logic             out_valid;
  logic             out_ready;
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_ovf, out_valid
  );
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_ovf, out_valid
  );
endinterface

// File: rtl/fp16_to_fixed_serial.sv
// fp16_to_fixed_serial: serial fp16 to signed fixed-point converter, one alignment shift per clock
//   clk, rst_n (async, active-low)
//   bus.slave: in_data[15:0], in_valid, in_ready, out_data[OUT_W-1:0], out_ovf, out_valid, out_ready
//   Optional macro FP16_TO_FIXED_ROUND_EN: round half away from zero on right shifts (default truncates).
module fp16_to_fixed_serial #(
  parameter int OUT_W  = 16,
  parameter int FRAC_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fp16_to_fixed_serial_if.slave bus
);
  localparam int CNT_W = $clog2(OUT_W + 13);
  localparam logic [OUT_W-1:0] POS_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] NEG_MIN = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W:0]   POS_LIM = {2'b00, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W:0]   NEG_LIM = {2'b01, {(OUT_W-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, SHIFT, APPLY, DONE} state_t;
  state_t            state_q, state_d;
  logic [OUT_W:0]    mag_q, mag_d, mag_r;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sign_q, sign_d, left_q, left_d, ovf_q, ovf_d;
  logic [OUT_W-1:0]  out_data_q, out_data_d;
  logic              out_ovf_q, out_ovf_d;
  logic [4:0]        exp_in;
  logic signed [31:0] s_in, s_abs;
  logic              accept, flush, sat_in, short_in, sat_r;
  assign exp_in   = bus.in_data[14:10];
  assign s_in     = $signed({27'd0, exp_in}) + FRAC_W - 25;
  assign s_abs    = s_in < 0 ? -s_in : s_in;
  assign accept   = bus.in_valid && state_q == IDLE;
  // zero/subnormal and far-right shifts resolve to 0; Inf/NaN and far-left shifts saturate
  assign flush    = exp_in == 5'd0 || s_in < -12;
  assign sat_in   = exp_in == 5'd31 || s_in > OUT_W;
  assign short_in = flush || sat_in;
`ifdef FP16_TO_FIXED_ROUND_EN
  logic rnd_q, rnd_d;
  assign rnd_d = accept ? 1'b0 : (state_q == SHIFT && !left_q) ? mag_q[0] : rnd_q;
  // rnd_q only ever holds a right-shift remainder, so the increment applies to s<0 alone
  assign mag_r = mag_q + {{OUT_W{1'b0}}, rnd_q};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rnd_q <= 1'b0;
    else rnd_q <= rnd_d;
  end
`else
  assign mag_r = mag_q;
`endif
  assign sat_r = ovf_q || (sign_q ? mag_r > NEG_LIM : mag_r > POS_LIM);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mag_q      <= '0;
      cnt_q      <= '0;
      sign_q     <= 1'b0;
      left_q     <= 1'b0;
      ovf_q      <= 1'b0;
      out_data_q <= '0;
      out_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mag_q      <= mag_d;
      cnt_q      <= cnt_d;
      sign_q     <= sign_d;
      left_q     <= left_d;
      ovf_q      <= ovf_d;
      out_data_q <= out_data_d;
      out_ovf_q  <= out_ovf_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  state_d = !accept ? IDLE : short_in ? DONE : s_in == 0 ? APPLY : SHIFT;
      SHIFT: state_d = cnt_q == 1 ? APPLY : SHIFT;
      APPLY: state_d = DONE;
      DONE:  state_d = bus.out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    mag_d      = mag_q;
    cnt_d      = cnt_q;
    sign_d     = sign_q;
    left_d     = left_q;
    ovf_d      = ovf_q;
    out_data_d = out_data_q;
    out_ovf_d  = out_ovf_q;
    if (accept) begin
      sign_d = bus.in_data[15];
      mag_d  = {{(OUT_W-10){1'b0}}, 1'b1, bus.in_data[9:0]};
      cnt_d  = CNT_W'(s_abs);
      left_d = s_in > 0;
      ovf_d  = 1'b0;
      if (short_in) begin
        out_data_d = flush ? '0 : bus.in_data[15] ? NEG_MIN : POS_MAX;
        out_ovf_d  = !flush;
      end
    end else if (state_q == SHIFT) begin
      mag_d = left_q ? mag_q << 1 : mag_q >> 1;
      ovf_d = ovf_q || (left_q && mag_q[OUT_W]);
      cnt_d = cnt_q - 1'b1;
    end else if (state_q == APPLY) begin
      out_data_d = sat_r ? (sign_q ? NEG_MIN : POS_MAX) :
                   sign_q ? -mag_r[OUT_W-1:0] : mag_r[OUT_W-1:0];
      out_ovf_d  = sat_r;
    end
  end
  always_comb begin
    bus.in_ready  = state_q == IDLE;
    bus.out_valid = state_q == DONE;
    bus.out_data  = out_data_q;
    bus.out_ovf   = out_ovf_q;
  end
endmodule

// File: tb/tb_fp16_to_fixed_serial.sv
// tb_fp16_to_fixed_serial: directed-vector bench for fp16_to_fixed_serial (OUT_W=16, FRAC_W=8)
module tb_fp16_to_fixed_serial;
`ifdef FP16_TO_FIXED_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif
  typedef struct {
    logic [15:0] d;
    int          lat;
    logic [15:0] q;
    logic        ovf;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  vec_t vecs [20];
  fp16_to_fixed_serial_if #(.OUT_W(16)) bus ();
  fp16_to_fixed_serial #(.OUT_W(16), .FRAC_W(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [15:0] d);
    check("in_ready_before_send", {31'd0, bus.in_ready}, 32'd1);
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = 16'($urandom);
  endtask
  task automatic expect_result(input string tag, input int lat, input logic [15:0] q, input logic ovf);
    int n = 1;
    while (!bus.out_valid && n < 64) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(lat));
    check({tag, "_data"}, {16'd0, bus.out_data}, {16'd0, q});
    check({tag, "_ovf"}, {31'd0, bus.out_ovf}, {31'd0, ovf});
  endtask
  task automatic release_out();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("valid_after_release", {31'd0, bus.out_valid}, 32'd0);
  endtask
  initial begin
    vecs = '{
      '{16'h3C00, 4,  16'h0100, 1'b0},
      '{16'hC500, 2,  16'hFB00, 1'b0},
      '{16'h5BD0, 7,  16'h7FFF, 1'b1},
      '{16'h7C00, 1,  16'h7FFF, 1'b1},
      '{16'hFC00, 1,  16'h8000, 1'b1},
      '{16'h2C20, 8,  RND ? 16'h0011 : 16'h0010, 1'b0},
      '{16'hAC20, 8,  RND ? 16'hFFEF : 16'hFFF0, 1'b0},
      '{16'h0000, 1,  16'h0000, 1'b0},
      '{16'h8000, 1,  16'h0000, 1'b0},
      '{16'h0001, 1,  16'h0000, 1'b0},
      '{16'h4000, 3,  16'h0200, 1'b0},
      '{16'hBC00, 4,  16'hFF00, 1'b0},
      '{16'h3C01, 4,  16'h0100, 1'b0},
      '{16'h3C02, 4,  RND ? 16'h0101 : 16'h0100, 1'b0},
      '{16'h5800, 7,  16'h7FFF, 1'b1},
      '{16'hD800, 7,  16'h8000, 1'b0},
      '{16'h7BFF, 15, 16'h7FFF, 1'b1},
      '{16'h1000, 1,  16'h0000, 1'b0},
      '{16'h1400, 14, 16'h0000, 1'b0},
      '{16'hFE00, 1,  16'h8000, 1'b1}
    };
    bus.in_data   = 16'h0000;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #12;
    check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_data", {16'd0, bus.out_data}, 32'd0);
    check("rst_ovf", {31'd0, bus.out_ovf}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++) begin
      send(vecs[i].d);
      expect_result($sformatf("vec_%h", vecs[i].d), vecs[i].lat, vecs[i].q, vecs[i].ovf);
      release_out();
    end
    send(16'h3C00);
    expect_result("bp", 4, 16'h0100, 1'b0);
    bus.in_data  = 16'h4000;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_valid", {31'd0, bus.out_valid}, 32'd1);
      check("bp_data", {16'd0, bus.out_data}, 32'h0100);
      check("bp_ovf", {31'd0, bus.out_ovf}, 32'd0);
      check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("bp_release_valid", {31'd0, bus.out_valid}, 32'd0);
    check("bp_release_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    expect_result("bp_next", 3, 16'h0200, 1'b0);
    release_out();
    send(16'h3C00);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_data", {16'd0, bus.out_data}, 32'd0);
    check("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mid_rst_ovf", {31'd0, bus.out_ovf}, 32'd0);
    check("mid_rst_ready", {31'd0, bus.in_ready}, 32'd1);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(16'h4000);
    expect_result("post_rst", 3, 16'h0200, 1'b0);
    release_out();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp16_to_fixed_serial.md
Name: fp16_to_fixed_serial

Overview:
- Multi-cycle converter from IEEE-754 half-precision (binary16) to signed two's-complement fixed point.
- It is the reading end of the fp16 format produced by the FFT/IFFT half-float add/sub datapath, and hands butterfly results to fixed-point sinks (magnitude, DAC, test readout).
- Alignment is done one bit-shift per clock, not with a barrel shifter.
- Valid/ready on both sides; one conversion in flight.

Parameters:
- OUT_W, 16: output width in bits, signed two's complement. Legal range is 12 or more.
- FRAC_W, 8: number of fractional bits in the output. Legal range is 0 to OUT_W-2.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_data  in  16  fp16 operand (sign[15], exp[14:10], mant[9:0])
- in_valid  in  1  operand valid
- in_ready  out  1  converter can accept an operand
- out_data  out  OUT_W  signed fixed-point result
- out_ovf  out  1  result saturated or input special; qualified by out_valid
- out_valid  out  1  result valid
- out_ready  in  1  sink accepts result

Behaviour:
- Reset, asynchronous, active-low:
  - State goes to IDLE.
  - out_data=0, out_ovf=0, out_valid=0, in_ready=1 (in_ready is combinational from state==IDLE).
  - Reset asserted mid-conversion aborts the conversion; the operand is discarded.
- States: IDLE, SHIFT, APPLY, DONE.
- IDLE:
  - in_ready=1. On in_valid&in_ready, capture sign, exp and mag={1,mant}. mag is OUT_W+1 bits, unsigned.
  - Compute s = exp - 25 + FRAC_W, signed.
  - exp==0 (zero or subnormal): result 0, ovf=0, go to DONE. Subnormals are flushed.
  - exp==31 (Inf/NaN): result is saturated by sign, ovf=1, go to DONE.
  - s > OUT_W: saturate, ovf=1, go to DONE.
  - s < -12: result 0, ovf=0, go to DONE.
  - s == 0: go to APPLY.
  - Otherwise: cnt=|s|, go to SHIFT.
- SHIFT, one bit per cycle; cnt decrements; go to APPLY when cnt reaches 1 and that shift completes:
  - Left (s>0): mag<<1. A 1 leaving mag's MSB sets sticky ovf.
  - Right (s<0): mag>>1, truncating toward zero. The bit shifted out is kept as rnd_bit, last value wins.
- APPLY, one cycle:
  - Limit is 2^(OUT_W-1)-1 for positive, 2^(OUT_W-1) for negative. If mag exceeds the limit or ovf is set: out_data = 0x7FF..F (positive) or 0x800..0 (negative), out_ovf=1.
  - Else out_data = sign ? -mag : mag.
  - A -0 result gives 0.
  - Go to DONE.
- DONE:
  - out_valid=1; out_data and out_ovf held stable.
  - On out_ready: out_valid falls next edge and state returns to IDLE.
  - No new operand is accepted in the same cycle (in_ready=0 outside IDLE).
- Latency from the accept edge to out_valid high:
  - |s|+2 edges in the normal case.
  - 1 edge for special or short-circuit cases.
- Throughput: one result per latency+1 cycles minimum.
- in_data is not required to remain stable after the accept edge.

Optional Feature:
- Macro FP16_TO_FIXED_ROUND_EN.
- Defined: round half away from zero on right shifts. In APPLY, if s<0 and rnd_bit=1, mag=mag+1 before the sign and saturation checks. The increment may cause saturation, which sets ovf.
- Undefined: pure truncation toward zero; rnd_bit logic is absent.
- Latency is identical in both builds.

Test Plan (OUT_W=16, FRAC_W=8):
- 0x3C00 (1.0), s=-2 -> out_data=0x0100, out_ovf=0; out_valid high 4 edges after accept.
- 0xC500 (-5.0), s=0 -> out_data=0xFB00, out_ovf=0; out_valid 2 edges after accept.
- 0x5BD0 (250.0), s=5 -> out_data=0x7FFF, out_ovf=1. 0x7C00 -> 0x7FFF, ovf=1. 0xFC00 -> 0x8000, ovf=1, latency 1.
- 0x2C20, s=-6, mag 1056 -> 0x0010 without macro; 0x0011 with FP16_TO_FIXED_ROUND_EN. 0x0000 and 0x8000 -> 0x0000, ovf=0, latency 1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_data and out_ovf stable, in_ready=0, a pending in_valid is not accepted; release out_ready -> next operand accepted the cycle after return to IDLE.
- Reset during SHIFT of 0x3C00: assert rst_n=0 mid-shift -> outputs 0 immediately and in_ready=1; after release, 0x4000 -> 0x0200 with normal latency.
